// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the 6-digit BCD display scanner.
// Segment codes are active-high, bit 0 = a ... bit 6 = g.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [5:0] DIG_OFF = 6'b111111;

  function automatic logic nib_invalid(input logic [3:0] n);
    return (n > 4'd9);
  endfunction

endpackage

// File: rtl/bcd7seg_decode.sv
// Combinational BCD nibble to active-high 7-segment code.
// Non-decimal nibbles (A-F) render as a dash.
module bcd7seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd6_display_scan.sv
// Snapshot + time-multiplexed scan of a 6-digit packed-BCD value.
// Define BCD6_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd6_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        F_IN,
  input  logic        CLR,
  input  logic        ENA,
  input  logic        LOAD,
  input  logic [23:0] D,
  output logic [6:0]  SEG,
  output logic [5:0]  DIG,
  output logic        ERR
);

  localparam logic [15:0] TC = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [15:0] r_presc;
  logic [2:0]  r_idx;
  logic [23:0] r_snap;
  logic [6:0]  r_seg;
  logic [5:0]  r_dig;
  logic        r_err;

  logic [3:0]  w_nib;
  logic [6:0]  w_seg_dec;
  logic [6:0]  w_seg;
  logic [5:0]  w_dig;
  logic        w_err;
  logic        w_tc;

  assign w_tc  = ENA && (r_presc == TC);
  assign w_nib = r_snap[{r_idx, 2'b00} +: 4];
  assign w_dig = ~(6'd1 << r_idx);

  bcd7seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_err = w_err | nib_invalid(r_snap[4*i +: 4]);
  end

`ifdef BCD6_LEADING_ZERO_BLANK_EN
  logic [5:0] w_nz;
  logic       w_blank;

  always_comb begin
    w_nz = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_nz[i] = |r_snap[4*i +: 4];
  end

  // Blank when this digit and everything above it is zero.
  assign w_blank = (r_idx != 3'd0) && ((w_nz >> r_idx) == 6'd0);
  assign w_seg   = w_blank ? SEG_BLANK : w_seg_dec;
`else
  assign w_seg = w_seg_dec;
`endif

  always_ff @(posedge F_IN) begin
    if (CLR) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_seg   <= SEG_BLANK;
      r_dig   <= DIG_OFF;
      r_err   <= 1'b0;
    end else begin
      if (LOAD)
        r_snap <= D;
      if (ENA) begin
        if (w_tc) begin
          r_presc <= '0;
          r_idx   <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
          r_presc <= r_presc + 16'd1;
        end
      end
      r_seg <= w_seg;
      r_dig <= w_dig;
      r_err <= w_err;
    end
  end

  assign SEG = r_seg;
  assign DIG = r_dig;
  assign ERR = r_err;

endmodule

// File: tb/tb_bcd6_display_scan.sv
// Directed bench for bcd6_display_scan with SCAN_DIV=2.
// Blanking expectations follow BCD6_LEADING_ZERO_BLANK_EN.
module tb_bcd6_display_scan;

  logic        F_IN = 1'b0;
  logic        CLR  = 1'b1;
  logic        ENA  = 1'b0;
  logic        LOAD = 1'b0;
  logic [23:0] D    = '0;
  logic [6:0]  SEG;
  logic [5:0]  DIG;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BCD6_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  bcd6_display_scan #(.SCAN_DIV(2)) dut (
    .F_IN (F_IN),
    .CLR  (CLR),
    .ENA  (ENA),
    .LOAD (LOAD),
    .D    (D),
    .SEG  (SEG),
    .DIG  (DIG),
    .ERR  (ERR)
  );

  always #5 F_IN = ~F_IN;

  task automatic tick();
    @(posedge F_IN);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [6:0] seg,
                         input logic [5:0] dig,
                         input logic err);
    check({tag, ".seg"}, 32'(SEG), 32'(seg));
    check({tag, ".dig"}, 32'(DIG), 32'(dig));
    check({tag, ".err"}, 32'(ERR), 32'(err));
  endtask

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [5:0] dig_of(input int d);
    return ~(6'd1 << d);
  endfunction

  initial begin
    // reset
    repeat (3) tick();
    chk_out("reset", 7'h00, 6'b111111, 1'b0);
    CLR = 1'b0;
    tick();
    chk_out("rel", 7'h3F, 6'b111110, 1'b0);
    repeat (5) tick();
    chk_out("rel_hold", 7'h3F, 6'b111110, 1'b0);

    // scan of 123456
    LOAD = 1'b1; D = 24'h123456; ENA = 1'b1;
    tick();
    chk_out("load_edge", 7'h3F, 6'b111110, 1'b0);
    LOAD = 1'b0;
    tick();
    chk_out("scan_d0", seg_of(6), 6'b111110, 1'b0);
    for (int d = 1; d < 6; d++) begin
      repeat (2) begin
        tick();
        chk_out($sformatf("scan_d%0d", d), seg_of(6 - d), dig_of(d), 1'b0);
      end
    end
    repeat (2) begin
      tick();
      chk_out("wrap_d0", seg_of(6), 6'b111110, 1'b0);
    end
    for (int d = 1; d < 3; d++) begin
      repeat (2) begin
        tick();
        chk_out($sformatf("scan2_d%0d", d), seg_of(6 - d), dig_of(d), 1'b0);
      end
    end
    tick();
    chk_out("pre_hold", 7'h4F, 6'b110111, 1'b0);

    // hold on disable
    ENA = 1'b0;
    repeat (10) begin
      tick();
      chk_out("hold", 7'h4F, 6'b110111, 1'b0);
    end
    ENA = 1'b1;
    tick();
    chk_out("resume_tc", 7'h4F, 6'b110111, 1'b0);
    tick();
    chk_out("resume_d4", 7'h5B, 6'b101111, 1'b0);

    // invalid nibble
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    LOAD = 1'b1; D = 24'h00A009;
    tick();
    LOAD = 1'b0;
    tick();
    chk_out("inv_d0", 7'h6F, 6'b111110, 1'b1);
    repeat (4) tick();
    tick();
    chk_out("inv_d3", 7'h40, 6'b110111, 1'b1);
    LOAD = 1'b1; D = 24'h000009;
    tick();
    chk_out("inv_clr_k", 7'h40, 6'b110111, 1'b1);
    LOAD = 1'b0;
    tick();
    chk_out("inv_clr_k1", LZ, 6'b101111, 1'b0);

    // reset overrides load
    CLR = 1'b1; LOAD = 1'b1; D = 24'h999999;
    tick();
    chk_out("clr_load", 7'h00, 6'b111111, 1'b0);
    CLR = 1'b0; LOAD = 1'b0; ENA = 1'b0;
    tick();
    chk_out("clr_rel", 7'h3F, 6'b111110, 1'b0);
    tick();
    chk_out("clr_snap0", 7'h3F, 6'b111110, 1'b0);

    // leading zeros on 000305
    ENA = 1'b1; LOAD = 1'b1; D = 24'h000305;
    tick();
    LOAD = 1'b0;
    tick();
    chk_out("lz_d0", 7'h6D, 6'b111110, 1'b0);
    tick();
    chk_out("lz_d1", 7'h3F, 6'b111101, 1'b0);
    tick();
    tick();
    chk_out("lz_d2", 7'h4F, 6'b111011, 1'b0);
    tick();
    tick();
    chk_out("lz_d3", LZ, 6'b110111, 1'b0);
    tick();
    tick();
    chk_out("lz_d4", LZ, 6'b101111, 1'b0);
    tick();
    tick();
    chk_out("lz_d5", LZ, 6'b011111, 1'b0);
    tick();
    LOAD = 1'b1; D = 24'h000000;
    tick();
    chk_out("z_old", 7'h6D, 6'b111110, 1'b0);
    LOAD = 1'b0;
    tick();
    chk_out("z_d0", 7'h3F, 6'b111110, 1'b0);
    tick();
    chk_out("z_d1", LZ, 6'b111101, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
